// File: rtl/reg_spill_fill.sv
// Spills the register file to data memory or fills it back from memory at a block base address.
// Strobes and pointers decode from registered state only; Start never reaches an output combinationally.
module reg_spill_fill #(
   parameter int NREGS      = 4,
   parameter int AW         = 2,
   parameter int DW         = 8,
   parameter int MAW        = 8,
   parameter int MEM_RD_LAT = 1
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           Start,
   input  logic           Dir,
   input  logic [MAW-1:0] BaseAddr,
   output logic           Busy,
   output logic           Done,
   output logic [AW-1:0]  RfRa,
   input  logic [DW-1:0]  RfRdat,
   output logic           RfWen,
   output logic [AW-1:0]  RfWd,
   output logic [DW-1:0]  RfWdat,
   output logic [MAW-1:0] MemAddr,
   output logic           MemWen,
   output logic [DW-1:0]  MemWdat,
   output logic           MemRen,
   input  logic [DW-1:0]  MemRdat
);

   typedef enum logic [2:0] {
      S_IDLE, S_SPILL, S_FILL_REQ, S_FILL_WAIT, S_FILL_WR, S_DONE
   } state_e;

   // FILL_WAIT lasts MEM_RD_LAT-1 cycles, so the counter only spans 0..MEM_RD_LAT-2.
   localparam int             CW        = (MEM_RD_LAT > 2) ? $clog2(MEM_RD_LAT - 1) : 1;
   localparam logic [CW-1:0]  WAIT_LAST = CW'((MEM_RD_LAT > 1) ? (MEM_RD_LAT - 2) : 0);
   localparam logic [AW-1:0]  IDX_LAST  = AW'(NREGS - 1);
   localparam bit             LAT1      = (MEM_RD_LAT == 1);

   state_e         state_q, state_d;
   logic [AW-1:0]  idx_q, idx_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [MAW-1:0] base_q, base_d;
   logic [MAW-1:0] blk_addr;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
      end
   end

   // Direction is captured by which active state Start leads to, so no separate Dir register is kept.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               base_d  = BaseAddr;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = Dir ? S_FILL_REQ : S_SPILL;
            end
         end
         S_SPILL: begin
            if (idx_q == IDX_LAST) state_d = S_DONE;
            else                   idx_d   = idx_q + AW'(1);
         end
         S_FILL_REQ: begin
            cnt_d   = '0;
            state_d = LAT1 ? S_FILL_WR : S_FILL_WAIT;
         end
         S_FILL_WAIT: begin
            if (cnt_q == WAIT_LAST) state_d = S_FILL_WR;
            else                    cnt_d   = cnt_q + CW'(1);
         end
         S_FILL_WR: begin
            if (idx_q == IDX_LAST) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + AW'(1);
               state_d = S_FILL_REQ;
            end
         end
         S_DONE: begin
            idx_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Block address wraps modulo 2**MAW.
   assign blk_addr = base_q + MAW'(idx_q);

   always_comb begin
      Busy    = 1'b0;
      Done    = 1'b0;
      RfRa    = '0;
      RfWen   = 1'b0;
      RfWd    = '0;
      RfWdat  = '0;
      MemAddr = '0;
      MemWen  = 1'b0;
      MemWdat = '0;
      MemRen  = 1'b0;
      case (state_q)
         S_SPILL: begin
            Busy    = 1'b1;
            RfRa    = idx_q;
            MemAddr = blk_addr;
            MemWdat = RfRdat;
            MemWen  = 1'b1;
         end
         S_FILL_REQ: begin
            Busy    = 1'b1;
            MemAddr = blk_addr;
            MemRen  = 1'b1;
         end
         S_FILL_WAIT: Busy = 1'b1;
         S_FILL_WR: begin
            Busy   = 1'b1;
            RfWen  = 1'b1;
            RfWd   = idx_q;
            RfWdat = MemRdat;
         end
         S_DONE:  Done = 1'b1;
         default: ;
      endcase
   end

endmodule
